// File: rtl/connect4_pkg.sv
// Shared constants, colour encoding and FSM state type for the connect-four draw sequencer.
package connect4_pkg;

    localparam int COLS = 7;
    localparam int ROWS = 6;

    localparam logic [2:0] COL_P0    = 3'b100;
    localparam logic [2:0] COL_P1    = 3'b110;
    localparam logic [2:0] BG_COLOUR = 3'b000;

    localparam logic [2:0] LAST_COL = 3'(COLS - 1);
    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PIECE     = 3'd1,
        PTR_ERASE = 3'd2,
        PTR_DRAW  = 3'd3,
        CLEAR     = 3'd4,
        DONE      = 3'd5
    } state_t;

    function automatic logic [2:0] player_colour(input logic player);
        return player ? COL_P1 : COL_P0;
    endfunction

    function automatic logic col_ok(input logic [2:0] col);
        return 32'(col) < COLS;
    endfunction

    function automatic logic row_ok(input logic [2:0] row);
        return 32'(row) < ROWS;
    endfunction

endpackage

// File: rtl/cell_scan_counter.sv
// 4-bit pixel index inside a 4x4 cell; wraps 15->0 so consecutive cells need no bubble.
module cell_scan_counter (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] count,
    output logic       last
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

    assign last = (count == 4'd15);

endmodule

// File: rtl/connect4_draw_sequencer.sv
// Arbitrates clear/piece/pointer draw requests and walks 4x4 cells with plot asserted.
// Handshake: each req is a level held until its 1-cycle ack; ack, plot and pixel 0 appear together.
module connect4_draw_sequencer
    import connect4_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear_req,
    input  logic       piece_req,
    input  logic [2:0] piece_col,
    input  logic [2:0] piece_row,
    input  logic       piece_player,
    input  logic       ptr_req,
    input  logic [2:0] ptr_col,
    input  logic       ptr_player,
    output logic       clear_ack,
    output logic       piece_ack,
    output logic       ptr_ack,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] pixel_count,
    output logic [2:0] cell_col,
    output logic [2:0] cell_row,
    output logic       ptr_row,
    output logic [2:0] colour,
    output logic       plot,
    output state_t     state_dbg
);

    state_t     state, state_next;
    logic       take_clear, take_piece, take_ptr, range_err;
    logic       busy_d, done_d, plot_d;
    logic       walking, last;
    logic       ptr_valid;
    logic [2:0] old_ptr_col, lat_ptr_col;
    logic       lat_ptr_player;

    assign walking   = (state == PIECE) || (state == PTR_ERASE) ||
                       (state == PTR_DRAW) || (state == CLEAR);
    assign state_dbg = state;

    cell_scan_counter u_scan (
        .clk    (clk),
        .resetn (resetn),
        .clr    (!walking),
        .en     (walking),
        .count  (pixel_count),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        take_clear = 1'b0;
        take_piece = 1'b0;
        take_ptr   = 1'b0;
        range_err  = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    take_clear = 1'b1;
                    state_next = CLEAR;
                end else if (piece_req) begin
                    take_piece = 1'b1;
                    range_err  = !col_ok(piece_col) || !row_ok(piece_row);
                    state_next = range_err ? DONE : PIECE;
                end else if (ptr_req) begin
                    take_ptr   = 1'b1;
                    range_err  = !col_ok(ptr_col);
                    state_next = range_err ? DONE : (ptr_valid ? PTR_ERASE : PTR_DRAW);
                end
            end
            PIECE:     if (last) state_next = DONE;
            PTR_ERASE: if (last) state_next = PTR_DRAW;
            PTR_DRAW:  if (last) state_next = DONE;
            CLEAR:     if (last && ptr_row && cell_col == LAST_COL) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_next != IDLE);
        done_d = (state_next == DONE);
        plot_d = (state_next == PIECE) || (state_next == PTR_ERASE) ||
                 (state_next == PTR_DRAW) || (state_next == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            clear_ack <= 1'b0;
            piece_ack <= 1'b0;
            ptr_ack   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            plot      <= 1'b0;
        end else begin
            clear_ack <= take_clear;
            piece_ack <= take_piece;
            ptr_ack   <= take_ptr;
            busy      <= busy_d;
            done      <= done_d;
            err       <= range_err;
            plot      <= plot_d;
        end
    end

    // Cell address/colour: loaded on acceptance, advanced when the pixel walk of a cell ends.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cell_col       <= 3'd0;
            cell_row       <= 3'd0;
            ptr_row        <= 1'b0;
            colour         <= 3'd0;
            ptr_valid      <= 1'b0;
            old_ptr_col    <= 3'd0;
            lat_ptr_col    <= 3'd0;
            lat_ptr_player <= 1'b0;
        end else if (take_clear) begin
            cell_col <= 3'd0;
            cell_row <= 3'd0;
            ptr_row  <= 1'b0;
            colour   <= BG_COLOUR;
        end else if (take_piece && !range_err) begin
            cell_col <= piece_col;
            cell_row <= piece_row;
            ptr_row  <= 1'b0;
            colour   <= player_colour(piece_player);
        end else if (take_ptr && !range_err) begin
            lat_ptr_col    <= ptr_col;
            lat_ptr_player <= ptr_player;
            ptr_row        <= 1'b1;
            cell_row       <= 3'd0;
            cell_col       <= ptr_valid ? old_ptr_col : ptr_col;
            colour         <= ptr_valid ? BG_COLOUR : player_colour(ptr_player);
        end else if (last) begin
            case (state)
                PTR_ERASE: begin
                    cell_col <= lat_ptr_col;
                    colour   <= player_colour(lat_ptr_player);
                end
                PTR_DRAW: begin
                    old_ptr_col <= lat_ptr_col;
                    ptr_valid   <= 1'b1;
                end
                CLEAR: begin
                    if (cell_col == LAST_COL) begin
                        cell_col <= 3'd0;
                        if (ptr_row) begin
                            ptr_valid <= 1'b0;
                        end else if (cell_row == LAST_ROW) begin
                            ptr_row  <= 1'b1;
                            cell_row <= 3'd0;
                        end else begin
                            cell_row <= cell_row + 3'd1;
                        end
                    end else begin
                        cell_col <= cell_col + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_connect4_draw_sequencer.sv
// Randomised bench for connect4_draw_sequencer: a board-level model queues every expected output cycle.
module tb_connect4_draw_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       clear_req, piece_req, ptr_req;
    logic [2:0] piece_col, piece_row, ptr_col;
    logic       piece_player, ptr_player;
    logic       clear_ack, piece_ack, ptr_ack, busy, done, err, ptr_row, plot;
    logic [3:0] pixel_count;
    logic [2:0] cell_col, cell_row, colour;
    logic [2:0] state_dbg;

    connect4_draw_sequencer dut (
        .clk(clk), .resetn(resetn),
        .clear_req(clear_req), .piece_req(piece_req), .piece_col(piece_col),
        .piece_row(piece_row), .piece_player(piece_player),
        .ptr_req(ptr_req), .ptr_col(ptr_col), .ptr_player(ptr_player),
        .clear_ack(clear_ack), .piece_ack(piece_ack), .ptr_ack(ptr_ack),
        .busy(busy), .done(done), .err(err), .pixel_count(pixel_count),
        .cell_col(cell_col), .cell_row(cell_row), .ptr_row(ptr_row),
        .colour(colour), .plot(plot), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // record: busy, ack{clear,piece,ptr}, plot, done, err, ptr_row, col, row, colour, pixel
    logic [20:0] exp_q[$];
    int          exp_len_q[$];

    bit          m_ptr_valid;
    logic [2:0]  m_old_col;

    function automatic logic [2:0] m_colour(input logic p);
        return p ? 3'b110 : 3'b100;
    endfunction

    function automatic logic [20:0] plot_rec(input logic [2:0] ack, input logic prow,
                                             input logic [2:0] col, input logic [2:0] row,
                                             input logic [2:0] colr, input logic [3:0] pix);
        return {1'b1, ack, 1'b1, 1'b0, 1'b0, prow, col, row, colr, pix};
    endfunction

    function automatic logic [20:0] done_rec(input logic [2:0] ack, input logic e);
        return {1'b1, ack, 1'b0, 1'b1, e, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0};
    endfunction

    // ---------------- reference model ----------------
    task automatic push_cell(input logic [2:0] col, input logic [2:0] row, input logic prow,
                             input logic [2:0] colr, input logic [2:0] ack);
        for (int p = 0; p < 16; p++)
            exp_q.push_back(plot_rec((p == 0) ? ack : 3'b000, prow, col,
                                     prow ? 3'd0 : row, colr, 4'(p)));
    endtask

    task automatic model_clear();
        logic [2:0] a;
        a = 3'b100;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++) begin
                push_cell(3'(c), 3'(r), 1'b0, 3'b000, a);
                a = 3'b000;
            end
        for (int c = 0; c < 7; c++) push_cell(3'(c), 3'd0, 1'b1, 3'b000, 3'b000);
        exp_q.push_back(done_rec(3'b000, 1'b0));
        exp_len_q.push_back(7 * 7 * 16);
        m_ptr_valid = 1'b0;
    endtask

    task automatic model_piece(input logic [2:0] c, input logic [2:0] r, input logic p);
        if (c >= 3'd7 || r >= 3'd6) begin
            exp_q.push_back(done_rec(3'b010, 1'b1));
            exp_len_q.push_back(0);
        end else begin
            push_cell(c, r, 1'b0, m_colour(p), 3'b010);
            exp_q.push_back(done_rec(3'b000, 1'b0));
            exp_len_q.push_back(16);
        end
    endtask

    task automatic model_ptr(input logic [2:0] c, input logic p);
        if (c >= 3'd7) begin
            exp_q.push_back(done_rec(3'b001, 1'b1));
            exp_len_q.push_back(0);
        end else begin
            if (m_ptr_valid) begin
                push_cell(m_old_col, 3'd0, 1'b1, 3'b000, 3'b001);
                push_cell(c, 3'd0, 1'b1, m_colour(p), 3'b000);
                exp_len_q.push_back(32);
            end else begin
                push_cell(c, 3'd0, 1'b1, m_colour(p), 3'b001);
                exp_len_q.push_back(16);
            end
            exp_q.push_back(done_rec(3'b000, 1'b0));
            m_old_col   = c;
            m_ptr_valid = 1'b1;
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    int          cyc = 0;
    int          ack_cyc = 0;
    int          el;
    logic [20:0] act, e, mask;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (plot || done || clear_ack || piece_ack || ptr_ack) begin
            act = {busy, clear_ack, piece_ack, ptr_ack, plot, done, err, ptr_row,
                   cell_col, cell_row, colour, pixel_count};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output got %h expected none", act);
            end else begin
                e    = exp_q.pop_front();
                mask = '1;
                if (e[15]) mask[13:4] = '0;
                if (e[13]) mask[9:7]  = '0;
                if ((act & mask) !== (e & mask)) begin
                    n_fail++;
                    $display("FAIL scoreboard cyc=%0d got %h expected %h", cyc, act & mask, e & mask);
                end
            end
            if (clear_ack || piece_ack || ptr_ack) ack_cyc = cyc;
            if (done && exp_len_q.size() > 0) begin
                el = exp_len_q.pop_front();
                n_tests++;
                if (cyc - ack_cyc != el) begin
                    n_fail++;
                    $display("FAIL op_latency got %0d expected %0d", cyc - ack_cyc, el);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int budget;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while ((busy || exp_q.size() != 0) && budget < 2000);
        n_tests++;
        if (budget >= 2000 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL idle_drain got %0d pending expected 0", exp_q.size());
            exp_q.delete();
            exp_len_q.delete();
        end
    endtask

    task automatic issue(input bit dc, input bit dp, input logic [2:0] pc, input logic [2:0] pr,
                         input logic pp, input bit dq, input logic [2:0] qc, input logic qp);
        int budget;
        if (dc) model_clear();
        if (dp) model_piece(pc, pr, pp);
        if (dq) model_ptr(qc, qp);
        piece_col = pc; piece_row = pr; piece_player = pp;
        ptr_col = qc; ptr_player = qp;
        clear_req = dc; piece_req = dp; ptr_req = dq;
        budget = 0;
        while ((clear_req || piece_req || ptr_req) && budget < 4000) begin
            @(negedge clk);
            budget++;
            if (clear_ack) clear_req = 1'b0;
            if (piece_ack) piece_req = 1'b0;
            if (ptr_ack)   ptr_req   = 1'b0;
        end
        if (budget >= 4000) begin
            n_tests++; n_fail++;
            $display("FAIL ack_timeout got reqs %b expected 000", {clear_req, piece_req, ptr_req});
            clear_req = 1'b0; piece_req = 1'b0; ptr_req = 1'b0;
        end
        wait_idle();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_req = 1'b0; piece_req = 1'b0; ptr_req = 1'b0;
        piece_col = 3'd0; piece_row = 3'd0; piece_player = 1'b0;
        ptr_col = 3'd0; ptr_player = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({clear_ack, piece_ack, ptr_ack, busy, done, err, plot, ptr_row,
             pixel_count, cell_col, cell_row, colour} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b expected all 0",
                     {clear_ack, piece_ack, ptr_ack, busy, done, err, plot, ptr_row,
                      pixel_count, cell_col, cell_row, colour});
        end
        m_ptr_valid = 1'b0;
        m_old_col   = 3'd0;
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic abort_in_ptr_draw();
        int budget;
        issue(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0);
        model_ptr(3'd5, 1'b1);
        ptr_col = 3'd5; ptr_player = 1'b1; ptr_req = 1'b1;
        budget = 0;
        while (budget < 200) begin
            @(negedge clk);
            budget++;
            if (ptr_ack) ptr_req = 1'b0;
            if (plot && ptr_row && colour == 3'b110 && pixel_count == 4'd8) break;
        end
        resetn  = 1'b0;
        ptr_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (budget >= 200 || {plot, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_abort got plot/busy/done=%b budget=%0d expected 000", {plot, busy, done}, budget);
        end
        exp_q.delete();
        exp_len_q.delete();
        m_ptr_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        issue(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        do_reset();
        issue(1'b0, 1'b1, 3'd3, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0);
        issue(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0);
        issue(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1);
        issue(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0);
        issue(1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1, 3'd6, 1'b1);
        issue(1'b0, 1'b1, 3'd7, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        issue(1'b0, 1'b1, 3'd0, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0);
        issue(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd7, 1'b0);
        issue(1'b0, 1'b1, 3'd6, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0);
        abort_in_ptr_draw();
        for (int i = 0; i < 30; i++) begin
            int k;
            k = $urandom_range(0, 9);
            issue(k == 0, (k == 0) || (k >= 1 && k <= 4) || (k == 9),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  (k == 0) || (k >= 5),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
